// File: rtl/fifo_pkg.sv
// Shared pointer helpers for FIFO controllers (word count, full and empty predicates).
// Latency: pure combinational functions, no state.
// Backpressure: not applicable; callers derive their ready/valid flags from these predicates.
package fifo_pkg;

    // Depth of the output buffer that hides the RAM read latency
    localparam logic [1:0] FIFO_OBUF_DEPTH = 2'd2;

    // Words between write and read pointers; pointers are aw+1 bits and wrap naturally
    function automatic logic [31:0] fifo_count(input logic [31:0] wptr,
                                               input logic [31:0] rptr,
                                               input int          aw);
        logic [31:0] mask;
        mask = (32'd1 << (aw + 1)) - 32'd1;
        return (wptr - rptr) & mask;
    endfunction

    // Full when the pointers differ only in their MSB
    function automatic logic fifo_is_full(input logic [31:0] cnt, input int aw);
        return cnt == (32'd1 << aw);
    endfunction

    // Empty when the pointers are identical, MSB included
    function automatic logic fifo_is_empty(input logic [31:0] cnt);
        return cnt == 32'd0;
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: odata is registered one cycle after ord; same-address write in that cycle returns old data.
// Backpressure: none; the caller decides when to write and when to read.
module dp_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iclk,
    input  logic                  iwr,
    input  logic [ADDR_WIDTH-1:0] iaddr,
    input  logic [DATA_WIDTH-1:0] idata,
    input  logic                  oclk,
    input  logic                  ord,
    input  logic [ADDR_WIDTH-1:0] oaddr,
    output logic [DATA_WIDTH-1:0] odata,
    output logic                  odata_valid
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_odata;
    logic                  r_ord_q;

    // Write port: store the payload when iwr is set
    always_ff @(posedge iclk) begin
        if (iwr) begin
            r_mem[iaddr] <= idata;
        end
    end

    // Read port: register the addressed word and a matching valid flag (no reset)
    always_ff @(posedge oclk) begin
        if (ord) begin
            r_odata <= r_mem[oaddr];
        end
        r_ord_q <= ord;
    end

    assign odata       = r_odata;
    assign odata_valid = r_ord_q;

endmodule

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO around one dp_ram with a 2-entry output buffer.
// Latency: a word written at edge k is presented on out_data/out_valid from edge k+2.
// Backpressure: in_ready drops when the RAM holds 2**ADDR_WIDTH words; reads pause while the buffer is full.
module sync_fwft_fifo
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic                  r_rd_pend;
    logic [1:0]            r_buf_cnt;
    logic [DATA_WIDTH-1:0] r_buf0;
    logic [DATA_WIDTH-1:0] r_buf1;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_ram_empty;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_occ;
    logic [DATA_WIDTH-1:0] w_odata;
    logic                  w_unused_odata_valid;

    assign w_count     = PTR_W'(fifo_count(32'(r_wptr), 32'(r_rptr), ADDR_WIDTH));
    assign w_full      = fifo_is_full(32'(w_count), ADDR_WIDTH);
    assign w_ram_empty = fifo_is_empty(32'(w_count));

    // Built only from registered state and rst, so in_valid never feeds back into in_ready
    assign in_ready = !w_full && !rst;
    assign w_wr     = in_valid && in_ready;

    assign out_valid = (r_buf_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_rd_pend;

    // Buffered plus in-flight words; a pop this cycle frees a slot in time for a read issued now,
    // which is what lets the output side sustain one word per clock
    assign w_occ = r_buf_cnt + {1'b0, r_rd_pend};
    assign w_rd  = !rst && !w_ram_empty && (w_occ < (FIFO_OBUF_DEPTH + {1'b0, w_pop}));

    assign out_data = r_buf0;
    assign count    = w_count;

    // RAM data is taken on r_rd_pend; odata_valid is unused because its flop has no reset
    dp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .iclk        (clk),
        .iwr         (w_wr),
        .iaddr       (r_wptr[ADDR_WIDTH-1:0]),
        .idata       (in_data),
        .oclk        (clk),
        .ord         (w_rd),
        .oaddr       (r_rptr[ADDR_WIDTH-1:0]),
        .odata       (w_odata),
        .odata_valid (w_unused_odata_valid)
    );

    // Advance pointers on write/read issue and remember a read is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_pend <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            r_rd_pend <= w_rd;
        end
    end

    // Two-entry in-order output buffer: r_buf0 is the head, r_buf1 the tail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_cnt <= 2'd0;
            r_buf0    <= '0;
            r_buf1    <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_buf0 <= w_odata;
                    end else begin
                        r_buf1 <= w_odata;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf0    <= r_buf1;
                    r_buf_cnt <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        r_buf0 <= w_odata;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_odata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fwft_fifo.sv
module tb_sync_fwft_fifo;

    localparam int AW    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   count;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] sb[$];

    sync_fwft_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive inputs for one cycle, report which transfers happen at the coming edge
    task automatic tick(input logic iv, input logic [DW-1:0] id, input logic ordy,
                        output logic inf, output logic outf, output logic [DW-1:0] od);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        @(negedge clk);
        inf  = in_valid && in_ready;
        outf = out_valid && out_ready;
        od   = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_during: got %b want 0", out_valid); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic inf, outf;
        logic [DW-1:0] od, exp_v;
        int fire_c, first_c;
        fire_c = -1; first_c = -1;
        sb.delete();
        for (int c = 0; c < 12; c++) begin
            tick((fire_c < 0), 32'hDEADBEEF, 1'b1, inf, outf, od);
            if (inf) begin sb.push_back(32'hDEADBEEF); fire_c = c; end
            if (outf) begin
                if (first_c < 0) first_c = c;
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL single_extra: got %h want none", od); end
                else begin
                    exp_v = sb.pop_front();
                    if (od !== exp_v) begin n_err++; $display("FAIL single_data: got %h want %h", od, exp_v); end
                end
            end
        end
        // first visible 3 negedges after the fire negedge = edge k+2
        n_cmp++;
        if ((fire_c < 0) || (first_c - fire_c != 3)) begin
            n_err++; $display("FAIL single_latency: got fire=%0d first_out=%0d want gap 3", fire_c, first_c);
        end
    endtask

    task automatic test_fill();
        logic inf, outf;
        logic [DW-1:0] od, exp_v;
        int acc, rcv;
        acc = 0; rcv = 0;
        sb.delete();
        for (int c = 0; c < 14; c++) begin
            tick(1'b1, 32'(acc), 1'b0, inf, outf, od);
            if (inf) begin sb.push_back(32'(acc)); acc++; end
        end
        n_cmp++;
        if (acc != DEPTH + 2) begin n_err++; $display("FAIL fill_accepted: got %0d want %0d", acc, DEPTH + 2); end
        n_cmp++;
        if (count !== (AW+1)'(DEPTH)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, '0, 1'b1, inf, outf, od);
            if (outf) begin
                rcv++;
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL fill_extra: got %h want none", od); end
                else begin
                    exp_v = sb.pop_front();
                    if (od !== exp_v) begin n_err++; $display("FAIL fill_drain_data: got %h want %h", od, exp_v); end
                end
            end
        end
        n_cmp++;
        if (rcv != DEPTH + 2) begin n_err++; $display("FAIL fill_drained: got %0d want %0d", rcv, DEPTH + 2); end
    endtask

    task automatic test_back_to_back();
        logic inf, outf;
        logic [DW-1:0] od, exp_v;
        int sent, rcv, first_c, last_c, last_in;
        int n;
        n = 3 * DEPTH;
        sent = 0; rcv = 0; first_c = -1; last_c = -1; last_in = -1;
        sb.delete();
        for (int c = 0; c < 60 && rcv < n; c++) begin
            tick((sent < n), 32'h100 + 32'(sent), 1'b1, inf, outf, od);
            if (inf) begin sb.push_back(32'h100 + 32'(sent)); sent++; last_in = c; end
            if (outf) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                rcv++;
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL stream_extra: got %h want none", od); end
                else begin
                    exp_v = sb.pop_front();
                    if (od !== exp_v) begin n_err++; $display("FAIL stream_data: got %h want %h", od, exp_v); end
                end
            end
        end
        n_cmp++;
        if (rcv != n) begin n_err++; $display("FAIL stream_count: got %0d want %0d", rcv, n); end
        n_cmp++;
        if (last_c - first_c != n - 1) begin n_err++; $display("FAIL stream_out_rate: got span %0d want %0d", last_c - first_c, n - 1); end
        n_cmp++;
        if (last_in != n - 1) begin n_err++; $display("FAIL stream_in_rate: got last_in %0d want %0d", last_in, n - 1); end
    endtask

    task automatic test_random();
        logic inf, outf, iv, ordy;
        logic [DW-1:0] od, id, exp_v;
        int sent, rcv, cyc, n;
        n = 10000;
        sent = 0; rcv = 0; cyc = 0;
        sb.delete();
        while (rcv < n && cyc < 40000) begin
            iv   = (sent < n) && ($urandom_range(0, 9) < 7);
            id   = $urandom;
            ordy = ($urandom_range(0, 9) < 6);
            tick(iv, id, ordy, inf, outf, od);
            if (inf) begin sb.push_back(id); sent++; end
            if (outf) begin
                rcv++;
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL random_extra: got %h want none", od); end
                else begin
                    exp_v = sb.pop_front();
                    if (od !== exp_v) begin n_err++; $display("FAIL random_data: got %h want %h", od, exp_v); end
                end
            end
            n_cmp++;
            if (count > (AW+1)'(DEPTH)) begin n_err++; $display("FAIL random_count_bound: got %0d want <= %0d", count, DEPTH); end
            cyc++;
        end
        n_cmp++;
        if (rcv != n) begin n_err++; $display("FAIL random_timeout: got %0d words want %0d", rcv, n); end
    endtask

    task automatic test_reset_mid();
        logic inf, outf;
        logic [DW-1:0] od, exp_v;
        int sent, rcv;
        sent = 0; rcv = 0;
        sb.delete();
        for (int c = 0; c < 20; c++) begin
            tick(1'b1, 32'h1000 + 32'(sent), 1'b0, inf, outf, od);
            if (inf) begin sb.push_back(32'h1000 + 32'(sent)); sent++; end
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_full: got in_ready %b want 0", in_ready); end
        // pop one word so a refill read is issued and in flight at the reset edge
        tick(1'b0, '0, 1'b1, inf, outf, od);
        n_cmp++;
        if (!outf || sb.size() == 0) begin n_err++; $display("FAIL rstmid_pop: got fire %b want 1", outf); end
        else begin
            exp_v = sb.pop_front();
            if (od !== exp_v) begin n_err++; $display("FAIL rstmid_pop_data: got %h want %h", od, exp_v); end
        end
        rst = 1'b1;
        tick(1'b0, '0, 1'b0, inf, outf, od);
        rst = 1'b0;
        sb.delete();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_cmp++;
        if (count !== '0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_cmp++;
        if (out_data !== '0) begin n_err++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        for (int c = 0; c < 10; c++) begin
            tick((c == 0), 32'hA5, 1'b1, inf, outf, od);
            if (inf) sb.push_back(32'hA5);
            if (outf) begin
                rcv++;
                n_cmp++;
                if (sb.size() == 0) begin n_err++; $display("FAIL rstmid_stale: got %h want none", od); end
                else begin
                    exp_v = sb.pop_front();
                    if (od !== exp_v) begin n_err++; $display("FAIL rstmid_data: got %h want %h", od, exp_v); end
                end
            end
        end
        n_cmp++;
        if (rcv != 1) begin n_err++; $display("FAIL rstmid_words: got %0d want 1", rcv); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
